// File: rtl/top_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : top_pkg
//  Purpose  : Shared definitions for the direct-mapped write-back cache:
//             address field widths, controller state encoding and the
//             cache line record.
//  Revision : 1.0 - initial release
// ============================================================================
package top_pkg;

    localparam int TAG_W      = 4;
    localparam int IDX_W      = 2;
    localparam int OFF_W      = 2;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 2 ** OFF_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        RESP      = 3'd4
    } state_t;

    typedef struct packed {
        logic                                valid;
        logic                                dirty;
        logic [TAG_W-1:0]                    tag;
        logic [LINE_WORDS-1:0][DATA_W-1:0]   data;
    } line_t;

endpackage
`default_nettype wire

// File: rtl/top_main_memory.sv
`default_nettype none
// ============================================================================
//  Module   : top_main_memory
//  Purpose  : Word-addressed backing store for the cache. One port with a
//             synchronous write and a combinational read. Reset reloads
//             every word with its own index (mem[i] = i).
//  Ports    : clk, rst_n       clock / asynchronous active-low reset
//             we, addr, wdata  write enable, word address, write data
//             rdata            combinational read data at addr
//  Revision : 1.0 - initial release
// ============================================================================
module top_main_memory
    import top_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(i);
            end
        end else if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ============================================================================
//  Module   : top
//  Purpose  : Direct-mapped, write-back, write-allocate data cache in front
//             of an internal main memory. One load/store at a time.
//  Ports    : clk, rst_n     clock / asynchronous active-low reset
//             req_valid      request present
//             req_ready      idle and able to accept a request
//             write          1 = store, 0 = load
//             addr           byte address {tag, index, word offset, byte}
//             w_data         store data
//             done           one-cycle completion pulse
//             hit            lookup result of the last completed request
//             r_data         data of the last completed load
//             hit_count, miss_count, wb_count
//                            saturating statistics (only with CACHE_STATS_EN)
//  Options  : CACHE_STATS_EN adds the statistics counters and ports.
//  Revision : 1.0 - initial release
// ============================================================================
module top
    import top_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int NUM_BLOCKS      = 4,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int MEM_WORDS       = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       w_data,
    output logic              done,
    output logic              hit,
    output logic [31:0]       r_data
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
    output logic [15:0]       wb_count
`endif
);

    localparam int          MEM_AW     = $clog2(MEM_WORDS);
    localparam logic [OFF_W-1:0] C_LAST_WORD = OFF_W'(WORDS_PER_BLOCK - 1);

    state_t              r_state;
    state_t              w_next;
    line_t               r_lines [NUM_BLOCKS];
    logic [OFF_W-1:0]    r_cnt;
    logic [TAG_W-1:0]    r_tag;
    logic [IDX_W-1:0]    r_idx;
    logic [OFF_W-1:0]    r_off;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_hit;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_done;

    line_t               w_line;
    logic                w_hit;
    logic                w_accept;
    logic                w_mem_we;
    logic [MEM_AW-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0]   w_mem_rdata;

    // Byte-offset bits carry no information: all accesses are full words.
    logic w_unused_byte_off;
    assign w_unused_byte_off = &{1'b0, addr[1:0]};

    assign w_line    = r_lines[r_idx];
    assign w_hit     = w_line.valid && (w_line.tag == r_tag);
    // Ready drops for the done cycle so a new request lands one cycle later.
    assign req_ready = (r_state == IDLE) && !r_done;
    assign w_accept  = req_valid && req_ready;

    // Write-back streams the victim line out under its old tag; allocation
    // fetches under the requested tag. Only write-back writes memory.
    assign w_mem_we    = (r_state == WRITEBACK);
    assign w_mem_addr  = (r_state == WRITEBACK) ? {w_line.tag, r_idx, r_cnt}
                                                : {r_tag, r_idx, r_cnt};
    assign w_mem_wdata = w_line.data[r_cnt];

    top_main_memory #(
        .DEPTH (MEM_WORDS),
        .AW    (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_mem_we),
        .addr  (w_mem_addr),
        .wdata (w_mem_wdata),
        .rdata (w_mem_rdata)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = COMPARE;
            end
            COMPARE: begin
                if (w_hit)                            w_next = RESP;
                else if (w_line.valid && w_line.dirty) w_next = WRITEBACK;
                else                                  w_next = ALLOCATE;
            end
            WRITEBACK: begin
                if (r_cnt == C_LAST_WORD) w_next = ALLOCATE;
            end
            ALLOCATE: begin
                if (r_cnt == C_LAST_WORD) w_next = RESP;
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tag   <= '0;
            r_idx   <= '0;
            r_off   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_hit   <= 1'b0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_lines[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tag   <= addr[ADDR_W-1 -: TAG_W];
                        r_idx   <= addr[OFF_W+2 +: IDX_W];
                        r_off   <= addr[2 +: OFF_W];
                        r_write <= write;
                        r_wdata <= w_data;
                    end
                end
                COMPARE: begin
                    r_hit <= w_hit;
                    r_cnt <= '0;
                end
                WRITEBACK: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                ALLOCATE: begin
                    r_lines[r_idx].data[r_cnt] <= w_mem_rdata;
                    r_lines[r_idx].tag         <= r_tag;
                    r_lines[r_idx].valid       <= 1'b1;
                    r_lines[r_idx].dirty       <= 1'b0;
                    r_cnt                      <= r_cnt + 1'b1;
                end
                RESP: begin
                    if (r_write) begin
                        r_lines[r_idx].data[r_off] <= r_wdata;
                        r_lines[r_idx].dirty       <= 1'b1;
                    end else begin
                        r_rdata <= w_line.data[r_off];
                    end
                    r_done <= 1'b1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign done   = r_done;
    assign hit    = r_hit;
    assign r_data = r_rdata;

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;
    logic [15:0] r_wb_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else if (r_state == COMPARE) begin
            if (w_hit) begin
                if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
            end else begin
                if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
                if ((w_next == WRITEBACK) && (r_wb_count != 16'hFFFF)) begin
                    r_wb_count <= r_wb_count + 16'd1;
                end
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
    assign wb_count   = r_wb_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_top
//  Purpose  : Self-checking bench for the cache top. A driver issues directed
//             requests and queues the expected hit / r_data / latency; a
//             monitor pops and compares on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_top;
    import top_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        write = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] w_data = '0;
    logic        req_ready;
    logic        done;
    logic        hit;
    logic [31:0] r_data;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [15:0] wb_count;
`endif

    top dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .write     (write),
        .addr      (addr),
        .w_data    (w_data),
        .done      (done),
        .hit       (hit),
        .r_data    (r_data)
`ifdef CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count),
        .wb_count  (wb_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    e = q.pop_front();
                    check({e.name, "_hit"},   {31'b0, hit}, {31'b0, e.hit});
                    check({e.name, "_rdata"}, r_data, e.rdata);
                    check({e.name, "_lat"},   32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input string nm, input bit wr, input logic [9:0] a,
                         input logic [31:0] d, input bit eh,
                         input logic [31:0] er, input int el, input bit track);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got req_ready=0 expected 1", nm);
            return;
        end
        req_valid = 1'b1;
        write     = wr;
        addr      = a;
        w_data    = d;
        if (track) q.push_back('{name: nm, hit: eh, rdata: er, lat: el, acc: cyc + 1});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_done",  {31'b0, done},      32'd0);
        check("rst_hit",   {31'b0, hit},       32'd0);
        check("rst_rdata", r_data,             32'd0);

        // Cold miss on line 1, allocate words 4..7.
        issue("ld_01c", 1'b0, 10'h01C, 32'h0, 1'b0, 32'h7, 6, 1'b1);
        drain();
        check("l1_tag_a",   {28'b0, dut.r_lines[1].tag}, 32'h0);
        check("l1_w0_a",    dut.r_lines[1].data[0], 32'h4);
        check("l1_dirty_a", {31'b0, dut.r_lines[1].dirty}, 32'd0);

        // Store hit: cache only, memory untouched.
        issue("st_018", 1'b1, 10'h018, 32'hFFFFFFFF, 1'b1, 32'h7, 2, 1'b1);
        drain();
        check("l1_w2_b",    dut.r_lines[1].data[2], 32'hFFFFFFFF);
        check("l1_dirty_b", {31'b0, dut.r_lines[1].dirty}, 32'd1);
        check("mem6_b",     dut.u_mem.r_mem[6], 32'h6);

        // Dirty eviction of line 1 by tag 1100.
        issue("ld_31d", 1'b0, 10'h31D, 32'h0, 1'b0, 32'hC7, 10, 1'b1);
        drain();
        check("mem4_c", dut.u_mem.r_mem[4], 32'h4);
        check("mem6_c", dut.u_mem.r_mem[6], 32'hFFFFFFFF);
        check("mem7_c", dut.u_mem.r_mem[7], 32'h7);
        check("l1_tag_c", {28'b0, dut.r_lines[1].tag}, 32'hC);
        check("l1_w0_c",  dut.r_lines[1].data[0], 32'hC4);

        // Store miss into invalid line 0.
        issue("st_008", 1'b1, 10'h008, 32'h0, 1'b0, 32'hC7, 6, 1'b1);
        drain();
        check("l0_w1_d", dut.r_lines[0].data[1], 32'h1);
        check("l0_w2_d", dut.r_lines[0].data[2], 32'h0);
        check("l0_w3_d", dut.r_lines[0].data[3], 32'h3);
        check("mem2_d",  dut.u_mem.r_mem[2], 32'h2);

        // Clean-line replacement, then a back-to-back load hit.
        issue("st_012", 1'b1, 10'h012, 32'h66666666, 1'b0, 32'hC7, 6, 1'b1);
        issue("ld_010", 1'b0, 10'h010, 32'h0, 1'b1, 32'h66666666, 2, 1'b1);
        drain();
        check("mem198_e", dut.u_mem.r_mem[198], 32'hC6);
        check("mem199_e", dut.u_mem.r_mem[199], 32'hC7);
        check("l1_tag_e", {28'b0, dut.r_lines[1].tag}, 32'h0);
        check("l1_w0_e",  dut.r_lines[1].data[0], 32'h66666666);
        check("l1_w2_e",  dut.r_lines[1].data[2], 32'hFFFFFFFF);

        // Dirty miss aborted by reset in the middle of write-back.
        issue("ld_31c_abort", 1'b0, 10'h31C, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(dut.r_state), 32'(IDLE));
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_hit",   {31'b0, hit}, 32'd0);
        check("abort_rdata", r_data, 32'd0);
        check("abort_l1_valid", {31'b0, dut.r_lines[1].valid}, 32'd0);
        check("abort_mem4",  dut.u_mem.r_mem[4], 32'h4);
        check("abort_mem6",  dut.u_mem.r_mem[6], 32'h6);

        // Memory is back to identity after reset.
        issue("ld_018_post", 1'b0, 10'h018, 32'h0, 1'b0, 32'h6, 6, 1'b1);
        drain();
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
